// File: rtl/d_branch_unit.sv
// d_branch_unit
//   Decode-stage branch resolution. Evaluates beq/bne and the sign/zero
//   branches on forwarded operands, trains a table of 2-bit saturating
//   predictors that fetch reads, flags mispredicts against the prediction
//   carried down from fetch, and keeps saturating branch/mispredict counters.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   f_pc          fetch PC used for predictor lookup
//   f_pred_taken  prediction for f_pc (MSB of the indexed counter)
//   d_valid       D-stage instruction valid
//   d_stall       D-stage stalled; nothing resolves while high
//   d_pc          PC of the D-stage instruction (selects predictor entry)
//   d_cmpop       compare mode (0 none,1 beq,2 bne,3 blez,4 bgtz,5 bltz,6 bgez,7 none)
//   d_rs, d_rt    forwarded operands
//   d_pred_taken  prediction the instruction carried from fetch
//   jump_b        branch taken (combinational)
//   mispredict    resolved outcome differs from d_pred_taken (combinational)
//   stat_clr      synchronous clear of the statistics counters
//   br_cnt        saturating count of resolved branches
//   miss_cnt      saturating count of mispredicts
module d_branch_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PHT_DEPTH  = 64,
  parameter int unsigned CNT_W      = 16,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       f_pc,
  output logic              f_pred_taken,
  input  logic              d_valid,
  input  logic              d_stall,
  input  logic [31:0]       d_pc,
  input  logic [2:0]        d_cmpop,
  input  logic [DATA_W-1:0] d_rs,
  input  logic [DATA_W-1:0] d_rt,
  input  logic              d_pred_taken,
  output logic              jump_b,
  output logic              mispredict,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned IDX_W = $clog2(PHT_DEPTH);

  logic [1:0]       r_pht [PHT_DEPTH];
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  logic [IDX_W-1:0] w_f_idx;
  logic [IDX_W-1:0] w_d_idx;
  logic             w_go;
  logic             w_is_br;
  logic             w_cond;
  logic             w_taken;
  logic             w_res;
  logic             w_miss;
  logic             w_rs_neg;
  logic             w_rs_zero;
  logic             w_eq;
  logic             w_unused;

  // PC word-offset bits and bits above the index do not select an entry.
  assign w_f_idx  = f_pc[IDX_W+1:2];
  assign w_d_idx  = d_pc[IDX_W+1:2];
  assign w_unused = ^{f_pc[31:IDX_W+2], f_pc[1:0], d_pc[31:IDX_W+2], d_pc[1:0]};

  assign w_rs_neg  = d_rs[DATA_W-1];
  assign w_rs_zero = (d_rs == '0);
  assign w_eq      = (d_rs == d_rt);

  always_comb begin
    w_cond  = 1'b0;
    w_is_br = 1'b1;
    case (d_cmpop)
      3'd1:    w_cond = w_eq;
      3'd2:    w_cond = ~w_eq;
      3'd3:    w_cond = w_rs_neg | w_rs_zero;
      3'd4:    w_cond = ~w_rs_neg & ~w_rs_zero;
      3'd5:    w_cond = w_rs_neg;
      3'd6:    w_cond = ~w_rs_neg;
      default: w_is_br = 1'b0;
    endcase
  end

  assign w_go    = d_valid & ~d_stall;
  assign w_taken = w_go & w_cond;
  assign w_res   = w_go & w_is_br;
  assign w_miss  = w_res & (w_taken != d_pred_taken);

  assign jump_b       = w_taken;
  assign mispredict   = w_miss;
  // No bypass: a same-cycle update to this entry shows up next cycle.
  assign f_pred_taken = r_pht[w_f_idx][1];
  assign br_cnt       = r_br_cnt;
  assign miss_cnt     = r_miss_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < PHT_DEPTH; i++) begin
        r_pht[i] <= INIT_STATE;
      end
    end else if (w_res) begin
      if (w_taken) begin
        if (r_pht[w_d_idx] != 2'b11) r_pht[w_d_idx] <= r_pht[w_d_idx] + 2'd1;
      end else begin
        if (r_pht[w_d_idx] != 2'b00) r_pht[w_d_idx] <= r_pht[w_d_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_br_cnt   <= '0;
      r_miss_cnt <= '0;
    end else if (stat_clr) begin
      r_br_cnt   <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_res && (r_br_cnt != '1))    r_br_cnt   <= r_br_cnt + CNT_W'(1);
      if (w_miss && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_d_branch_unit.sv
module tb_d_branch_unit;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned CW    = 4;
  localparam int          CMAX  = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   f_pc = '0;
  logic          f_pred_taken;
  logic          d_valid = 1'b0;
  logic          d_stall = 1'b0;
  logic [31:0]   d_pc = '0;
  logic [2:0]    d_cmpop = '0;
  logic [DW-1:0] d_rs = '0;
  logic [DW-1:0] d_rt = '0;
  logic          d_pred_taken = 1'b0;
  logic          jump_b;
  logic          mispredict;
  logic          stat_clr = 1'b0;
  logic [CW-1:0] br_cnt;
  logic [CW-1:0] miss_cnt;

  d_branch_unit #(
    .DATA_W    (DW),
    .PHT_DEPTH (DEPTH),
    .CNT_W     (CW),
    .INIT_STATE(2'b01)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .f_pc        (f_pc),
    .f_pred_taken(f_pred_taken),
    .d_valid     (d_valid),
    .d_stall     (d_stall),
    .d_pc        (d_pc),
    .d_cmpop     (d_cmpop),
    .d_rs        (d_rs),
    .d_rt        (d_rt),
    .d_pred_taken(d_pred_taken),
    .jump_b      (jump_b),
    .mispredict  (mispredict),
    .stat_clr    (stat_clr),
    .br_cnt      (br_cnt),
    .miss_cnt    (miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          jb;
    logic          mp;
    logic          fp;
    logic [CW-1:0] br;
    logic [CW-1:0] miss;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: predictor strengths 0..3 and plain integer counters.
  int m_pht [DEPTH];
  int m_br;
  int m_miss;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic bit cond_of(input int op, input logic [31:0] rs, input logic [31:0] rt);
    int s;
    s = $signed(rs);
    case (op)
      1: return rs == rt;
      2: return rs != rt;
      3: return s <= 0;
      4: return s > 0;
      5: return s < 0;
      6: return s >= 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_pht[i] = 1;
    m_br = 0;
    m_miss = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents outputs; compare with the queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("jump_b", int'(jump_b), int'(e.jb));
      chk("mispredict", int'(mispredict), int'(e.mp));
      chk("f_pred_taken", int'(f_pred_taken), int'(e.fp));
      chk("br_cnt", int'(br_cnt), int'(e.br));
      chk("miss_cnt", int'(miss_cnt), int'(e.miss));
    end
  end

  // One cycle of stimulus: drive, queue expected outputs, then advance the model
  // to the state the next clock edge should produce.
  task automatic step(input bit valid, input bit stall, input logic [31:0] pc,
                      input int op, input logic [31:0] rs, input logic [31:0] rt,
                      input bit pred, input logic [31:0] fpc, input bit clr);
    exp_t e;
    bit   go, jb, res, mp;
    @(posedge clk);
    #1;
    reset        = 1'b1;
    d_valid      = valid;
    d_stall      = stall;
    d_pc         = pc;
    d_cmpop      = 3'(op);
    d_rs         = rs;
    d_rt         = rt;
    d_pred_taken = pred;
    f_pc         = fpc;
    stat_clr     = clr;
    go  = valid && !stall;
    jb  = go && cond_of(op, rs, rt);
    res = go && (op >= 1 && op <= 6);
    mp  = res && (jb != pred);
    e.jb   = jb;
    e.mp   = mp;
    e.fp   = (m_pht[idx_of(fpc)] >= 2);
    e.br   = CW'(m_br);
    e.miss = CW'(m_miss);
    q.push_back(e);
    if (clr) begin
      m_br = 0;
      m_miss = 0;
    end else begin
      if (res) m_br = (m_br + 1 > CMAX) ? CMAX : m_br + 1;
      if (mp)  m_miss = (m_miss + 1 > CMAX) ? CMAX : m_miss + 1;
    end
    if (res) begin
      if (jb) m_pht[idx_of(pc)] = (m_pht[idx_of(pc)] == 3) ? 3 : m_pht[idx_of(pc)] + 1;
      else    m_pht[idx_of(pc)] = (m_pht[idx_of(pc)] == 0) ? 0 : m_pht[idx_of(pc)] - 1;
    end
  endtask

  task automatic do_reset(input logic [31:0] fpc);
    exp_t e;
    @(posedge clk);
    #1;
    d_valid = 1'b0; d_stall = 1'b0; d_pc = '0; d_cmpop = '0;
    d_rs = '0; d_rt = '0; d_pred_taken = 1'b0; stat_clr = 1'b0;
    f_pc  = fpc;
    reset = 1'b0;
    model_reset();
    e.jb = 1'b0; e.mp = 1'b0; e.fp = 1'b0; e.br = '0; e.miss = '0;
    q.push_back(e);
  endtask

  task automatic idle(input logic [31:0] fpc);
    step(0, 0, 32'h0, 0, 32'h0, 32'h0, 0, fpc, 0);
  endtask

  function automatic logic [31:0] rand_pc();
    return 32'h3000 + ($urandom_range(0, 7) << 2) + ($urandom_range(0, 1) * DEPTH * 4)
           + $urandom_range(0, 3);
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] v;
    model_reset();
    // Reset and the first taken beq.
    do_reset(32'h3000);
    idle(32'h3000);
    step(1, 0, 32'h3000, 1, 32'h5, 32'h5, 0, 32'h3000, 0);
    idle(32'h3000);
    // Sign/zero modes on the most negative value and on zero.
    for (int op = 3; op <= 6; op++) step(1, 0, 32'h3100, op, 32'h8000_0000, 32'h1234, 1, 32'h3100, 0);
    for (int op = 3; op <= 6; op++) step(1, 0, 32'h3100, op, 32'h0, 32'hFFFF, 0, 32'h3100, 0);
    // Saturate, then back off, with an aliased PC for the last one.
    for (int i = 0; i < 4; i++) step(1, 0, 32'h3004, 1, 32'h7, 32'h7, 1, 32'h3004, 0);
    step(1, 0, 32'h3004, 1, 32'h7, 32'h8, 1, 32'h3004, 0);
    idle(32'h3004);
    step(1, 0, 32'h3004 + 4 * DEPTH, 1, 32'h7, 32'h8, 1, 32'h3004, 0);
    idle(32'h3004);
    // Stall for three cycles, then resolve.
    for (int i = 0; i < 3; i++) step(1, 1, 32'h3008, 1, 32'h9, 32'h9, 0, 32'h3008, 0);
    step(1, 0, 32'h3008, 1, 32'h9, 32'h9, 0, 32'h3008, 0);
    idle(32'h3008);
    // None and reserved compare modes.
    step(1, 0, 32'h300C, 0, 32'h1, 32'h1, 1, 32'h300C, 0);
    step(1, 0, 32'h300C, 7, 32'h1, 32'h1, 1, 32'h300C, 0);
    idle(32'h300C);
    // Counter saturation, then clear during a branch.
    for (int i = 0; i < 20; i++) step(1, 0, 32'h3010, 2, 32'h1, 32'h2, 0, 32'h3010, 0);
    idle(32'h3010);
    step(1, 0, 32'h3010, 1, 32'h1, 32'h1, 0, 32'h3010, 1);
    idle(32'h3010);
    // Mid-run reset, then sweep every entry.
    do_reset(32'h3010);
    for (int i = 0; i < DEPTH; i++) idle(32'h3000 + 32'(i * 4));
    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(rand_pc());
      end else begin
        v = rand_val();
        step($urandom_range(0, 7) != 0, $urandom_range(0, 4) == 0, rand_pc(),
             $urandom_range(0, 7), v, ($urandom_range(0, 1) != 0) ? v : rand_val(),
             $urandom_range(0, 1), rand_pc(), $urandom_range(0, 39) == 0);
      end
    end
    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
